// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, mid-bit sampling, stop check.
// Ports: i_clk, i_rst (async high), i_rx in; o_data, o_valid, o_frame_err, o_active out.
module uart_rx #(
  parameter int p_CLK_DIV  = 104,
  parameter int p_WORD_LEN = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rx,
  output logic [p_WORD_LEN:0] o_data,
  output logic                o_valid,
  output logic                o_frame_err,
  output logic                o_active
);

  localparam int CW = $clog2(p_CLK_DIV) + 1;
  localparam int IW = $clog2(p_WORD_LEN) + 1;

  localparam logic [CW-1:0] DIV  = CW'(p_CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(p_CLK_DIV / 2);
  localparam logic [IW-1:0] LAST = IW'(p_WORD_LEN);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t              state;
  logic                s1;
  logic                s2;
  logic                s3;
  logic [2:0]          primed;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [p_WORD_LEN:0] shift;

  // primed[2] marks s3 as holding a real line sample rather than its
  // reset value, so a line that is low at reset release is not taken
  // as a falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      s1          <= 1'b1;
      s2          <= 1'b1;
      s3          <= 1'b1;
      primed      <= '0;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_active    <= 1'b0;
    end else begin
      s1          <= i_rx;
      s2          <= s1;
      s3          <= s2;
      primed      <= {primed[1:0], 1'b1};
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (primed[2] && s3 && !s2) begin
            state    <= START;
            o_active <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!s2) begin
              state <= DATA;
            end else begin
              state    <= IDLE;
              o_active <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == DIV) begin
            cnt        <= '0;
            shift[idx] <= s2;
            if (idx == LAST) begin
              idx   <= '0;
              state <= STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == DIV) begin
            cnt      <= '0;
            o_active <= 1'b0;
            if (s2) begin
              o_data  <= shift;
              o_valid <= 1'b1;
              state   <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (s2) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          idx      <= '0;
          o_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table of frames plus directed corner sequences.
// Drives i_rx on falling clock edges, samples outputs on falling edges.
module tb_uart_rx;

  localparam int T = 105;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [8:0] data;
  logic       valid;
  logic       ferr;
  logic       active;

  uart_rx dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_active    (active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int         v_count = 0;
  int         e_count = 0;
  int         r_count = 0;
  int         v_cyc   = 0;
  int         e_cyc   = 0;
  int         r_cyc   = 0;
  int         f_cyc   = 0;
  logic       act_q   = 1'b0;
  logic [8:0] vq[$];
  int         vcq[$];

  always @(negedge clk) begin
    if (valid && ferr) begin
      errors++;
      $display("FAIL pulse_overlap: valid=%0b frame_err=%0b", valid, ferr);
    end
    if (valid) begin
      v_count++;
      v_cyc = cyc;
      vq.push_back(data);
      vcq.push_back(cyc);
    end
    if (ferr) begin
      e_count++;
      e_cyc = cyc;
    end
    if (active && !act_q) begin
      r_count++;
      r_cyc = cyc;
    end
    if (!active && act_q) f_cyc = cyc;
    act_q = active;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int fall_cyc;

  // Call at a falling clock edge; line falls now (edge 0 = last posedge).
  task automatic send_frame(input logic [8:0] w, input logic stop,
                            input int hold);
    fall_cyc = cyc;
    rx = 1'b0;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      rx = w[i];
      repeat (T) @(negedge clk);
    end
    rx = stop;
    repeat (T + hold) @(negedge clk);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [8:0] word;
    logic       stop;
    int         hold;
    int         exp_valid;
    int         exp_err;
    logic [8:0] exp_data;
  } vec_t;

  vec_t vec[7];

  int v0, e0, r0;
  logic [8:0] lb[$];

  initial begin
    vec[0] = '{9'h1A5, 1'b1, 0,   1, 0, 9'h1A5};
    vec[1] = '{9'h0F0, 1'b0, 300, 0, 1, 9'h1A5};
    vec[2] = '{9'h055, 1'b1, 0,   1, 0, 9'h055};
    vec[3] = '{9'h100, 1'b1, 0,   1, 0, 9'h100};
    vec[4] = '{9'h001, 1'b1, 0,   1, 0, 9'h001};
    vec[5] = '{9'h0AA, 1'b0, 0,   0, 1, 9'h001};
    vec[6] = '{9'h1FF, 1'b1, 0,   1, 0, 9'h1FF};

    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr", ferr, 0);
    check("rst_active", active, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      v0 = v_count;
      e0 = e_count;
      r0 = r_count;
      send_frame(vec[i].word, vec[i].stop, vec[i].hold);
      repeat (20) @(negedge clk);
      check($sformatf("v%0d_valid_cnt", i), v_count - v0, vec[i].exp_valid);
      check($sformatf("v%0d_err_cnt", i), e_count - e0, vec[i].exp_err);
      check($sformatf("v%0d_data", i), data, vec[i].exp_data);
      check($sformatf("v%0d_starts", i), r_count - r0, 1);
      check($sformatf("v%0d_active_rise", i), r_cyc - fall_cyc, 3);
      check($sformatf("v%0d_active_fall", i), f_cyc - fall_cyc, 1106);
      check($sformatf("v%0d_pulse_edge", i),
            (vec[i].exp_valid != 0 ? v_cyc : e_cyc) - fall_cyc, 1106);
    end

    v0 = v_count;
    e0 = e_count;
    r0 = r_count;
    fall_cyc = cyc;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    check("fs_starts", r_count - r0, 1);
    check("fs_rise", r_cyc - fall_cyc, 3);
    check("fs_fall", f_cyc - fall_cyc, 56);
    check("fs_valid", v_count - v0, 0);
    check("fs_err", e_count - e0, 0);
    check("fs_data", data, 9'h1FF);

    vq.delete();
    vcq.delete();
    e0 = e_count;
    send_frame(9'h000, 1'b1, 0);
    send_frame(9'h1FF, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("b2b_count", vq.size(), 2);
    check("b2b_err", e_count - e0, 0);
    if (vq.size() == 2) begin
      check("b2b_data0", vq[0], 9'h000);
      check("b2b_data1", vq[1], 9'h1FF);
      check("b2b_gap", vcq[1] - vcq[0], 1155);
    end

    rx = 1'b0;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (T) @(negedge clk);
    end
    rx = 1'b0;
    repeat (50) @(negedge clk);
    check("mid_active", active, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_data", data, 0);
    check("mid_rst_active", active, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_ferr", ferr, 0);
    @(negedge clk);
    rst = 1'b0;
    v0 = v_count;
    e0 = e_count;
    r0 = r_count;
    repeat (T - 51 + 4 * T) @(negedge clk);
    rx = 1'b1;
    repeat (T + 300) @(negedge clk);
    check("post_rst_valid", v_count - v0, 0);
    check("post_rst_err", e_count - e0, 0);
    check("post_rst_starts", r_count - r0, 0);
    send_frame(9'h055, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("post_rst_frame_valid", v_count - v0, 1);
    check("post_rst_frame_data", data, 9'h055);

    vq.delete();
    e0 = e_count;
    for (int i = 0; i < 40; i++) begin
      logic [8:0] w;
      w = 9'($urandom_range(0, 511));
      lb.push_back(w);
      send_frame(w, 1'b1, 0);
    end
    repeat (20) @(negedge clk);
    check("lb_count", vq.size(), 40);
    check("lb_err", e_count - e0, 0);
    for (int i = 0; i < 40; i++) begin
      if (i < vq.size()) check($sformatf("lb_word%0d", i), vq[i], lb[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
